// File: rtl/dvi_scan_controller.sv
// Purpose: DVI raster timing, FWFT pixel FIFO read sequencing, and underrun blackout with flush/re-arm.
// Latency: read_en, fifo_flush and frame_start are combinational; hsync/vsync/blank/pixel_* are one cycle behind the counters.
// Backpressure: none; the raster runs freely, and an empty FIFO in the active region is treated as an underrun, not a stall.
module dvi_scan_controller #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [23:0] fifo_color,
    output logic        read_en,
    output logic        fifo_flush,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic [7:0]  pixel_r,
    output logic [7:0]  pixel_g,
    output logic [7:0]  pixel_b,
    output logic [15:0] underrun_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One extra value of headroom so the sync-end bound always fits, even with a zero back porch.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_ACT_L = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS    = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_MAX   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_L = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS    = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_MAX   = VW'(V_TOTAL - 1);

    typedef enum logic [1:0] {IDLE, ARM, RUN, UNDERRUN} state_t;

    state_t          state;
    state_t          next_state;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            active;
    logic            in_hs;
    logic            in_vs;
    logic            frame_wrap;
    logic            vsync_first;
    logic            underrun_evt;

    // Raster decode from the current counter position.
    assign active      = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
    assign in_hs       = (h_cnt >= H_SS) && (h_cnt < H_SE);
    assign in_vs       = (v_cnt >= V_SS) && (v_cnt < V_SE);
    assign frame_wrap  = (h_cnt == H_MAX) && (v_cnt == V_MAX);
    assign vsync_first = (h_cnt == '0) && (v_cnt == V_SS);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decision; dropping enable always returns to IDLE without a flush.
    always_comb begin
        next_state = state;
        if (!enable) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE:     next_state = ARM;
                ARM:      if (frame_wrap && !fifo_empty) next_state = RUN;
                RUN:      if (active && fifo_empty) next_state = UNDERRUN;
                UNDERRUN: if (vsync_first) next_state = ARM;
                default:  next_state = IDLE;
            endcase
        end
    end

    // FSM outputs: FIFO pop, flush request, frame marker and underrun event.
    always_comb begin
        read_en      = 1'b0;
        fifo_flush   = 1'b0;
        frame_start  = 1'b0;
        underrun_evt = 1'b0;
        if (enable) begin
            frame_start = (state != IDLE) && (h_cnt == '0) && (v_cnt == '0);
            unique case (state)
                RUN: begin
                    read_en      = active && !fifo_empty;
                    underrun_evt = active && fifo_empty;
                end
                UNDERRUN: fifo_flush = vsync_first;
                default:  ;
            endcase
        end
    end

    // Raster counters: held at the origin while idle or disabled, otherwise free-running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!enable || state == IDLE) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_MAX) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Registered video outputs, aligned one cycle behind the counter position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync                       <= ~SYNC_POL;
            vsync                       <= ~SYNC_POL;
            blank                       <= 1'b0;
            {pixel_r, pixel_g, pixel_b} <= 24'h0;
        end else if (!enable || state == IDLE) begin
            hsync                       <= ~SYNC_POL;
            vsync                       <= ~SYNC_POL;
            blank                       <= 1'b0;
            {pixel_r, pixel_g, pixel_b} <= 24'h0;
        end else begin
            hsync                       <= in_hs ? SYNC_POL : ~SYNC_POL;
            vsync                       <= in_vs ? SYNC_POL : ~SYNC_POL;
            blank                       <= active;
            {pixel_r, pixel_g, pixel_b} <= read_en ? fifo_color : 24'h0;
        end
    end

    // Saturating underrun event counter; survives enable toggling, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_cnt <= 16'h0;
        end else if (underrun_evt && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end

endmodule
